// File: rtl/sample_ram_reader_if.sv
// Bank-array B port plus the outbound sample stream of the sample RAM reader.
// master: the reader (drives address/select and the stream).
// slave : the RAM bank array and the stream consumer together.
interface sample_ram_reader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int BLK_WIDTH  = 4,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] B_ADDR;
    logic [BLK_WIDTH-1:0]  B_Block_Address_vector;
    logic [DATA_WIDTH-1:0] B_Output_Data;
    logic [DATA_WIDTH-1:0] Out_Data;
    logic                  Out_Valid;
    logic                  Out_Ready;

    modport master (
        output B_ADDR, B_Block_Address_vector, Out_Data, Out_Valid,
        input  B_Output_Data, Out_Ready
    );

    modport slave (
        input  B_ADDR, B_Block_Address_vector, Out_Data, Out_Valid,
        output B_Output_Data, Out_Ready
    );
endinterface

// File: rtl/sample_ram_reader.sv
// Read-side controller for the banked sample RAM.
// Streams Length words starting at (Start_Block, Start_Address), walking across
// bank boundaries around the bank ring. Reads are issued only while the output
// FIFO has room for everything already in flight, so returning data never
// overflows it and back-pressure loses nothing.
module sample_ram_reader #(
    parameter int ADDR_WIDTH = 16,
    parameter int BLK_WIDTH  = 4,
    parameter int NUM_BLOCKS = 3,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 24,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Start,
    input  logic [ADDR_WIDTH-1:0]  Start_Address,
    input  logic [BLK_WIDTH-1:0]   Start_Block,
    input  logic [LEN_WIDTH-1:0]   Length,
    input  logic                   Abort,
    sample_ram_reader_if.master    bus,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Err
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = CW + 1;
    localparam int FCW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BLK_WIDTH-1:0]  r_blk;
    logic [LEN_WIDTH-1:0]  r_issue_cnt;
    logic [LEN_WIDTH-1:0]  r_xfer_cnt;
    logic [FCW-1:0]        r_flush_cnt;

    logic [RD_LATENCY-1:0] r_vld;
    logic [BLK_WIDTH-1:0]  r_blk_dly [RD_LATENCY];

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [CW-1:0]         r_count;
    logic                  r_out_valid;

    logic                  w_issue;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_zero_len;
    logic                  w_abort;
    logic                  w_done;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_credit;
    logic                  w_blk_bad;
    logic [SW-1:0]         w_inflight;
    logic [CW-1:0]         w_wr_idx;
    logic [CW-1:0]         w_count_nxt;

    assign w_blk_bad   = 32'(Start_Block) >= 32'(NUM_BLOCKS);
    assign w_pop       = r_out_valid & bus.Out_Ready;
    assign w_push      = r_vld[RD_LATENCY-1] & ~w_abort;
    assign w_credit    = ({1'b0, r_count} + w_inflight) < SW'(FIFO_DEPTH);
    assign w_wr_idx    = r_count - CW'(w_pop);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    assign bus.B_ADDR                 = r_addr;
    assign bus.B_Block_Address_vector = r_blk_dly[RD_LATENCY-1];
    assign bus.Out_Data               = r_mem[0];
    assign bus.Out_Valid              = r_out_valid;

    // Reads still travelling through the RAM pipeline.
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + SW'(r_vld[i]);
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_zero_len  = 1'b0;
        w_abort     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (w_blk_bad) begin
                        w_reject = 1'b1;
                    end else if (Length == '0) begin
                        w_zero_len = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                if (Abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_FLUSH;
                end else if (w_credit) begin
                    w_issue = 1'b1;
                    if (r_issue_cnt == LEN_WIDTH'(1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (Abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_FLUSH;
                end else if (w_pop && r_xfer_cnt == LEN_WIDTH'(1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == FCW'(RD_LATENCY - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, address/block walk around the ring, and word counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr      <= '0;
            r_blk       <= '0;
            r_issue_cnt <= '0;
            r_xfer_cnt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_addr      <= Start_Address;
                r_blk       <= Start_Block;
                r_issue_cnt <= Length;
                r_xfer_cnt  <= Length;
            end else begin
                if (w_issue) begin
                    r_addr      <= r_addr + 1'b1;
                    r_issue_cnt <= r_issue_cnt - 1'b1;
                    if (r_addr == '1) begin
                        if (r_blk == BLK_WIDTH'(NUM_BLOCKS - 1)) begin
                            r_blk <= '0;
                        end else begin
                            r_blk <= r_blk + 1'b1;
                        end
                    end
                end
                if (w_pop) begin
                    r_xfer_cnt <= r_xfer_cnt - 1'b1;
                end
            end
            if (w_abort) begin
                r_flush_cnt <= '0;
            end else if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // Read-return tracking: valid bits and issuing block, delayed to line up
    // with the data coming back from the banks.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                r_blk_dly[i] <= '0;
            end
        end else begin
            if (w_abort) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= w_issue;
                for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
            if (w_issue) begin
                r_blk_dly[0] <= r_blk;
            end
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_blk_dly[i] <= r_blk_dly[i-1];
            end
        end
    end

    // Output FIFO kept as a shift register so the head is always entry 0;
    // a push in the same cycle as a pop lands one slot lower.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_abort) begin
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (w_push && w_wr_idx == CW'(i)) begin
                    r_mem[i] <= bus.B_Output_Data;
                end
            end
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
        end
    end

    // Registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Busy <= 1'b0;
            Done <= 1'b0;
            Err  <= 1'b0;
        end else begin
            Busy <= (w_state_nxt != S_IDLE);
            Done <= w_zero_len | w_done;
            Err  <= w_reject;
        end
    end

endmodule

// File: tb/tb_sample_ram_reader.sv
// Directed bench for sample_ram_reader with a 3-bank, 1-cycle-latency RAM model.
// Each bank word encodes its own (block, address) so the stream can be checked.
module tb_sample_ram_reader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [15:0] Start_Address;
    logic [3:0]  Start_Block;
    logic [23:0] Length;
    logic        Abort;
    logic        Busy;
    logic        Done;
    logic        Err;

    sample_ram_reader_if #(.ADDR_WIDTH(16), .BLK_WIDTH(4), .DATA_WIDTH(64)) bus ();

    sample_ram_reader #(
        .ADDR_WIDTH(16), .BLK_WIDTH(4), .NUM_BLOCKS(3), .DATA_WIDTH(64),
        .LEN_WIDTH(24), .RD_LATENCY(1), .FIFO_DEPTH(4)
    ) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Start_Address(Start_Address),
        .Start_Block(Start_Block), .Length(Length), .Abort(Abort),
        .bus(bus), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] word_of(input logic [3:0] b, input logic [15:0] a);
        return {24'hDA7A00, 4'h0, b, 16'h0000, a};
    endfunction

    // Bank array: address registered, output mux steered by the block vector.
    logic [15:0] ram_addr_q;
    always @(posedge CLK) ram_addr_q <= bus.B_ADDR;
    assign bus.B_Output_Data = word_of(bus.B_Block_Address_vector, ram_addr_q);

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stream monitor, sampled on the falling edge.
    int          cyc = 0;
    int          busy_cnt, done_cnt, err_cnt;
    logic [63:0] got_q[$];
    int          got_cyc[$];
    logic        stall_prev = 1'b0;
    logic [63:0] stall_data;
    logic [15:0] prev_addr = '0;
    logic [3:0]  prev_blk = '0;
    int          addr_wrap_cyc, blk_sw_cyc;

    always @(negedge CLK) begin
        cyc++;
        if (Busy) busy_cnt++;
        if (Done) done_cnt++;
        if (Err)  err_cnt++;
        if (stall_prev && !RST) begin
            chk("stall_valid", 64'(bus.Out_Valid), 64'd1);
            chk("stall_data", bus.Out_Data, stall_data);
        end
        stall_prev = bus.Out_Valid && !bus.Out_Ready;
        stall_data = bus.Out_Data;
        if (bus.Out_Valid && bus.Out_Ready) begin
            got_q.push_back(bus.Out_Data);
            got_cyc.push_back(cyc);
        end
        if (prev_addr == 16'hFFFF && bus.B_ADDR == 16'h0000) addr_wrap_cyc = cyc;
        if (prev_blk == 4'd0 && bus.B_Block_Address_vector == 4'd1) blk_sw_cyc = cyc;
        prev_addr = bus.B_ADDR;
        prev_blk  = bus.B_Block_Address_vector;
    end

    task automatic clr();
        busy_cnt = 0;
        done_cnt = 0;
        err_cnt  = 0;
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic start_req(input logic [3:0] b, input logic [15:0] a, input logic [23:0] len);
        @(posedge CLK); #1;
        Start = 1'b1; Start_Block = b; Start_Address = a; Length = len;
        @(posedge CLK); #1;
        Start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (Busy && n < max_cyc) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, "_timeout"}, 64'(Busy), 64'd0);
        @(posedge CLK); #1;
    endtask

    task automatic chk_words(input string tag, input logic [63:0] exp[$]);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_q[$];
        logic [15:0] pat;
        logic [15:0] addr_before;
        int          n;

        RST = 1'b1; Start = 1'b0; Start_Address = '0; Start_Block = '0;
        Length = '0; Abort = 1'b0; bus.Out_Ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_err", 64'(Err), 64'd0);
        chk("rst_valid", 64'(bus.Out_Valid), 64'd0);
        chk("rst_addr", 64'(bus.B_ADDR), 64'd0);
        chk("rst_blk", 64'(bus.B_Block_Address_vector), 64'd0);
        RST = 1'b0;

        // Straight 8-word burst from block 0
        clr();
        start_req(4'd0, 16'h0000, 24'd8);
        wait_idle("t1", 100);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(word_of(4'd0, 16'(i)));
        chk_words("t1", exp_q);
        chk("t1_done", 64'(done_cnt), 64'd1);
        chk("t1_busy_cycles", 64'(busy_cnt), 64'd10);
        if (got_cyc.size() == 8) chk("t1_rate", 64'(got_cyc[7] - got_cyc[0]), 64'd7);
        else chk("t1_rate_n", 64'(got_cyc.size()), 64'd8);

        // Bank boundary crossing
        clr();
        addr_wrap_cyc = 0; blk_sw_cyc = 0;
        start_req(4'd0, 16'hFFFE, 24'd4);
        wait_idle("t2", 100);
        exp_q = '{64'hDA7A0000_0000FFFE, 64'hDA7A0000_0000FFFF,
                  64'hDA7A0001_00000000, 64'hDA7A0001_00000001};
        chk_words("t2", exp_q);
        chk("t2_done", 64'(done_cnt), 64'd1);
        chk("t2_blk_lag", 64'(blk_sw_cyc - addr_wrap_cyc), 64'd1);

        // Ring wrap from the last bank back to bank 0
        clr();
        start_req(4'd2, 16'hFFFF, 24'd2);
        wait_idle("t3", 100);
        exp_q = '{64'hDA7A0002_0000FFFF, 64'hDA7A0000_00000000};
        chk_words("t3", exp_q);
        chk("t3_done", 64'(done_cnt), 64'd1);

        // 16 words under back-pressure: 10-cycle stall then a toggling pattern
        clr();
        bus.Out_Ready = 1'b0;
        start_req(4'd1, 16'h0010, 24'd16);
        pat = 16'b1011_0010_1110_0101;
        n = 0;
        while (Busy && n < 400) begin
            @(posedge CLK); #1;
            bus.Out_Ready = (n < 10) ? 1'b0 : pat[n % 16];
            n++;
        end
        chk("t4_timeout", 64'(Busy), 64'd0);
        @(posedge CLK); #1;
        bus.Out_Ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(word_of(4'd1, 16'h0010 + 16'(i)));
        chk_words("t4", exp_q);
        chk("t4_done", 64'(done_cnt), 64'd1);

        // Abort after 5 words, then a fresh request
        clr();
        start_req(4'd0, 16'h0100, 24'd16);
        n = 0;
        while (got_q.size() < 5 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("t5_reach5", 64'(got_q.size() >= 5), 64'd1);
        Abort = 1'b1;
        @(posedge CLK); #1;
        Abort = 1'b0;
        chk("t5_valid_low", 64'(bus.Out_Valid), 64'd0);
        chk("t5_busy_flush", 64'(Busy), 64'd1);
        @(posedge CLK); #1;
        chk("t5_busy_low", 64'(Busy), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("t5_no_done", 64'(done_cnt), 64'd0);
        chk("t5_partial", 64'(got_q.size() >= 5 && got_q.size() <= 7), 64'd1);
        for (int i = 0; i < got_q.size(); i++)
            chk($sformatf("t5_w%0d", i), got_q[i], word_of(4'd0, 16'h0100 + 16'(i)));
        clr();
        start_req(4'd1, 16'h0005, 24'd3);
        wait_idle("t5b", 100);
        exp_q = '{64'hDA7A0001_00000005, 64'hDA7A0001_00000006, 64'hDA7A0001_00000007};
        chk_words("t5b", exp_q);
        chk("t5b_done", 64'(done_cnt), 64'd1);

        // Rejected block index
        clr();
        start_req(4'd3, 16'h0000, 24'd4);
        chk("t6_err", 64'(Err), 64'd1);
        chk("t6_err_busy", 64'(Busy), 64'd0);
        @(posedge CLK); #1;
        chk("t6_err_clr", 64'(Err), 64'd0);
        chk("t6_err_idle", 64'(Busy), 64'd0);

        // Zero length: Done only, no read activity
        addr_before = bus.B_ADDR;
        start_req(4'd1, 16'h1234, 24'd0);
        chk("t6_zl_done", 64'(Done), 64'd1);
        chk("t6_zl_busy", 64'(Busy), 64'd0);
        @(posedge CLK); #1;
        chk("t6_zl_clr", 64'(Done), 64'd0);
        chk("t6_zl_addr", 64'(bus.B_ADDR), 64'(addr_before));
        chk("t6_zl_valid", 64'(bus.Out_Valid), 64'd0);
        chk("t6_zl_errcnt", 64'(err_cnt), 64'd1);

        // Asynchronous reset mid-transfer, then recovery
        clr();
        bus.Out_Ready = 1'b0;
        start_req(4'd0, 16'h0040, 24'd16);
        repeat (4) @(posedge CLK);
        #1;
        chk("t7_pre_valid", 64'(bus.Out_Valid), 64'd1);
        RST = 1'b1;
        #1;
        chk("t7_busy", 64'(Busy), 64'd0);
        chk("t7_valid", 64'(bus.Out_Valid), 64'd0);
        chk("t7_data", bus.Out_Data, 64'd0);
        chk("t7_addr", 64'(bus.B_ADDR), 64'd0);
        chk("t7_blk", 64'(bus.B_Block_Address_vector), 64'd0);
        chk("t7_done", 64'(Done), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        bus.Out_Ready = 1'b1;
        clr();
        start_req(4'd2, 16'h0030, 24'd2);
        wait_idle("t7b", 100);
        exp_q = '{64'hDA7A0002_00000030, 64'hDA7A0002_00000031};
        chk_words("t7b", exp_q);
        chk("t7b_done", 64'(done_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
